store_align_buffer: RTL
=======================

STORE_ALIGN_BUFFER -- requirements
Module: store_align_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered store entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port st_valid  input  1  core presents a store request.
REQ-005 SHALL have port st_ready  output  1  buffer can accept a request this cycle.
REQ-006 SHALL have port st_addr  input  32  byte address of store.
REQ-007 SHALL have port st_data  input  32  unaligned store data in low bits (byte [7:0], half [15:0]).
REQ-008 SHALL have port st_sel  input  3  funct3: SB=000, SH=001, SW=010; other codes illegal.
REQ-009 SHALL have port mem_valid  output  1  head entry presented to data memory.
REQ-010 SHALL have port mem_ready  input  1  data memory accepts head entry this cycle.
REQ-011 SHALL have port mem_addr  output  32  word address, bits [1:0] always 0.
REQ-012 SHALL have port mem_wdata  output  32  lane-aligned write data.
REQ-013 SHALL have port mem_we  output  4  byte write enables, bit i = byte lane i.
REQ-014 SHALL have port misalign  output  1  one-cycle pulse flagging a rejected request.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-016 SHALL accept a request when st_valid && st_ready at a rising clk edge; st_ready = (count != DEPTH), independent of mem_ready (no full-bypass).
REQ-017 SHALL align SB: mem_wdata = st_data[7:0] replicated in all four lanes; mem_we = 4'b0001 << st_addr[1:0].
REQ-018 SHALL align SH: mem_wdata = st_data[15:0] replicated in both halves; mem_we = 4'b0011 if st_addr[1]=0, else 4'b1100.
REQ-019 SHALL align SW: mem_wdata = st_data; mem_we = 4'b1111.
REQ-020 SHALL store mem_addr = {st_addr[31:2], 2'b00} with each entry.
REQ-021 SHALL treat SH with st_addr[0]=1, SW with st_addr[1:0]!=0, or any illegal st_sel as misaligned: request consumed (handshake completes), nothing enqueued, misalign=1 for exactly the next cycle.
REQ-022 SHALL present the head entry with mem_valid = (count != 0); an entry accepted at edge N is visible on mem_* after edge N at the earliest (1-cycle latency).
REQ-023 SHALL remove the head entry when mem_valid && mem_ready; mem_addr/mem_wdata/mem_we SHALL remain stable while mem_valid && !mem_ready.
REQ-024 SHALL force mem_we = 4'b0000 whenever count == 0; mem_addr/mem_wdata are don't-care then.
REQ-025 SHALL on simultaneous enqueue and dequeue (count not 0, not DEPTH) keep count unchanged and preserve FIFO order.
REQ-026 SHALL on simultaneous misaligned request and dequeue decrement count by 1 only.
REQ-027 SHALL wrap read/write pointers modulo DEPTH without gaps or duplication.
REQ-028 SHALL ignore mem_ready when count == 0 (no underflow).

Reset
REQ-029 SHALL on rst_n=0, immediately and independent of clk: pointers=0, count=0, mem_valid=0, mem_we=0, misalign=0, st_ready=1 (observed after release).
REQ-030 SHALL discard all buffered entries when reset asserts mid-operation; no write completes from pre-reset contents.
REQ-031 SHALL leave entry storage data uninitialised; only control state is reset.

Structure
REQ-032 SHALL take SB/SH/SW funct3 constants and entry field widths from shared package store_pkg, also used by the load path.
REQ-033 SHALL implement alignment and misalign detection in one combinational sub-module store_lane_align; buffer/pointer logic stays in store_align_buffer.

Verification
REQ-034 SHALL check: SB addr 0x1003 data 0x000000A5, mem_ready=1 -> next cycle mem_addr 0x1000, mem_wdata 0xA5A5A5A5, mem_we 4'b1000.
REQ-035 SHALL check: SH addr 0x2002 data 0x0000BEEF -> mem_wdata 0xBEEFBEEF, mem_we 4'b1100; SW addr 0x3000 data 0x12345678 -> mem_we 4'b1111.
REQ-036 SHALL check: SW addr 0x3002 -> misalign pulses one cycle, count stays 0, mem_valid stays 0.
REQ-037 SHALL check: mem_ready=0, three back-to-back SW (DEPTH=2) -> st_ready drops after second, third held; release mem_ready -> three writes in order, outputs stable while stalled.
REQ-038 SHALL check: count=1, push and pop same cycle repeated 8 times -> count stays 1, pointers wrap, order preserved.
REQ-039 SHALL check: assert rst_n low with count=2 mid-cycle -> mem_valid and mem_we go 0 immediately; after release count=0, st_ready=1.

Source files
------------

// File: rtl/store_pkg.sv
// Shared store-path definitions: funct3 encodings, bus widths and the
// aligned store entry layout. The load path uses the same encodings.
package store_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LANES  = DATA_W / 8;

  // funct3 encodings of the store instructions
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // One buffered, lane-aligned memory write
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [LANES-1:0]  we;
  } store_entry_t;

  // Word address containing a byte address
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] byte_addr);
    return {byte_addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational store alignment: steers SB/SH/SW data onto the byte lanes
// selected by the low address bits and flags requests that cannot be
// expressed as a single aligned word write.
module store_lane_align
  import store_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [2:0]        sel_i,
  output store_entry_t      entry_o,
  output logic              misalign_o
);

  // Lane steering and misalignment check for one request
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    entry_o.addr  = word_addr(addr_i);
    entry_o.wdata = '0;
    entry_o.we    = '0;
    misalign_o    = 1'b0;
    case (sel_i)
      F3_SB: begin
        entry_o.wdata = {4{data_i[7:0]}};
        entry_o.we    = 4'b0001 << addr_i[1:0];
      end
      F3_SH: begin
        entry_o.wdata = {2{data_i[15:0]}};
        entry_o.we    = addr_i[1] ? 4'b1100 : 4'b0011;
        misalign_o    = addr_i[0];
      end
      F3_SW: begin
        entry_o.wdata = data_i;
        entry_o.we    = 4'b1111;
        misalign_o    = |addr_i[1:0];
      end
      default: begin
        // Unknown funct3 is rejected the same way as a misaligned access
        misalign_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_align_buffer.sv
// Store buffer: accepts core store requests, aligns them onto byte lanes,
// queues them in a DEPTH-entry FIFO and presents the oldest entry to data
// memory. Misaligned or illegal requests are consumed and flagged with a
// one-cycle misalign pulse instead of being queued.
module store_align_buffer
  import store_pkg::*;
#(
  parameter int DEPTH = 2
)
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [ADDR_W-1:0]       st_addr,
  input  logic [DATA_W-1:0]       st_data,
  input  logic [2:0]              st_sel,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic [LANES-1:0]        mem_we,
  output logic                    misalign,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  store_entry_t  entry_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          misalign_q;

  store_entry_t  new_entry;
  store_entry_t  head_entry;
  logic          req_misalign;
  logic          accept;
  logic          enq;
  logic          deq;

  store_lane_align u_align (
    .addr_i     (st_addr),
    .data_i     (st_data),
    .sel_i      (st_sel),
    .entry_o    (new_entry),
    .misalign_o (req_misalign)
  );

  // Full depends only on occupancy; a pop in the same cycle does not free a slot
  assign st_ready  = (count_q != CW'(DEPTH));
  assign accept    = st_valid && st_ready;
  assign enq       = accept && !req_misalign;
  assign mem_valid = (count_q != '0);
  assign deq       = mem_valid && mem_ready;

  assign head_entry = entry_mem_q[rd_ptr_q];
  assign mem_addr   = head_entry.addr;
  assign mem_wdata  = head_entry.wdata;
  assign mem_we     = mem_valid ? head_entry.we : '0;
  assign misalign   = misalign_q;
  assign count      = count_q;

  // Next pointer and occupancy values; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
    if (enq && !deq) begin
      count_d = count_q + CW'(1);
    end else if (!enq && deq) begin
      count_d = count_q - CW'(1);
    end
  end

  // Control state: pointers, occupancy and the registered misalign pulse
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= accept && req_misalign;
    end
  end

  // Entry storage written at the tail on each enqueue
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; clearing count and the pointers is
    // enough to make stale contents invisible, and mem_we is gated while empty.
    if (enq) begin
      entry_mem_q[wr_ptr_q] <= new_entry;
    end
  end

endmodule
